contador_reader: RTL and testbench

- Requester side of the pop-counter readout interface; drives `req` and `idx`, and accepts `data`/`valid` from the counter block.
- On a `start` pulse, while the datapath reports `IDLE`, it reads counters 0..NUM_CNT-1 in order and latches each value into a snapshot register bank.
- It then reports completion with `done`.
- It sits beside the counter block and feeds the host/status logic with a coherent snapshot of all FIFO pop counts.

---
 rtl/contador_pkg.sv | 16 +
 rtl/contador_snapshot_bank.sv | 35 +++
 rtl/contador_reader.sv | 161 ++++++++++++++++
 tb/tb_contador_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the pop-counter readout path: FSM state encoding and
// default counter geometry, also used by the counter block itself.
package contador_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_REQ  = 2'd1;
    localparam state_t S_GAP  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    localparam int DEF_DATA_W  = 5;
    localparam int DEF_NUM_CNT = 5;
    localparam int DEF_IDX_W   = 3;

endpackage

// File: rtl/contador_snapshot_bank.sv
// NUM_CNT x DATA_W snapshot register file: one write port selected by index,
// all entries visible in parallel on the flat counts bus.
module contador_snapshot_bank
    import contador_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      we,
    input  logic [IDX_W-1:0]          widx,
    input  logic [DATA_W-1:0]         wdata,
    output logic [NUM_CNT*DATA_W-1:0] counts
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (we && (widx == IDX_W'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign counts[gi*DATA_W +: DATA_W] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/contador_reader.sv
// Sweeps counters 0..NUM_CNT-1 over the req/valid readout port into a snapshot bank.
// Optional per-index response timeout: define CONTADOR_READER_TIMEOUT_EN.
module contador_reader
    import contador_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int IDX_W   = DEF_IDX_W
`ifdef CONTADOR_READER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      IDLE,
    input  logic [DATA_W-1:0]         data,
    input  logic                      valid,
    output logic                      req,
    output logic [IDX_W-1:0]          idx,
    output logic [NUM_CNT*DATA_W-1:0] counts,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              abort;
    logic              capture;
    logic              last_idx;
    logic              timeout_hit;

    // idx_reg doubles as the sweep position k.
    assign last_idx = (idx_reg == IDX_W'(NUM_CNT - 1));

`ifdef CONTADOR_READER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_reg, wait_next;

    assign timeout_hit = (state_reg == S_REQ) && !valid &&
                         (wait_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        wait_next = wait_reg;
        if (state_reg != S_REQ) begin
            wait_next = '0;
        end else if (!valid) begin
            wait_next = wait_reg + WAIT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            req_reg   <= 1'b0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Losing IDLE beats a simultaneous valid, so an aborting sweep never captures.
    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start && IDLE) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!IDLE || timeout_hit) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else if (valid) begin
                    capture    = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!IDLE) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else if (last_idx) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        req_next  = (state_next == S_REQ);
        busy_next = (state_next == S_REQ) || (state_next == S_GAP);
        done_next = (state_next == S_DONE);
        err_next  = abort;
        idx_next  = idx_reg;
        if ((state_reg == S_IDLE) && (state_next == S_REQ)) begin
            idx_next = '0;
        end else if ((state_reg == S_GAP) && (state_next == S_REQ)) begin
            idx_next = idx_reg + IDX_W'(1);
        end
    end

    contador_snapshot_bank #(
        .DATA_W  (DATA_W),
        .NUM_CNT (NUM_CNT),
        .IDX_W   (IDX_W)
    ) u_bank (
        .CLK    (CLK),
        .reset  (reset),
        .we     (capture),
        .widx   (idx_reg),
        .wdata  (data),
        .counts (counts)
    );

    assign req  = req_reg;
    assign idx  = idx_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_contador_reader.sv
// Directed bench for contador_reader: negedge-driven responder, expected snapshots
// queued at stimulus time and compared on done/err.
module tb_contador_reader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        IDLE;
    logic [4:0]  data;
    logic        valid;
    logic        req;
    logic [2:0]  idx;
    logic [24:0] counts;
    logic        busy;
    logic        done;
    logic        err;

    int passed = 0;
    int total  = 0;

    logic [4:0]  data_tab [8];
    int          delay_tab [8];
    logic [24:0] exp_q [$];
    logic [24:0] last_counts;

    always #5 CLK = ~CLK;

    contador_reader dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .IDLE   (IDLE),
        .data   (data),
        .valid  (valid),
        .req    (req),
        .idx    (idx),
        .counts (counts),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Responder: raises valid once req has been seen for delay_tab[idx]+1 cycles.
    initial begin
        int wcnt;
        wcnt  = 0;
        valid = 1'b0;
        data  = '0;
        forever begin
            @(negedge CLK);
            if (!req) begin
                valid = 1'b0;
                wcnt  = 0;
            end else begin
                wcnt++;
                valid = (wcnt > delay_tab[idx]);
                data  = data_tab[idx];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [24:0] model(input logic [24:0] prior, input int upto);
        logic [24:0] r;
        r = prior;
        for (int k = 0; k < upto; k++) r[k*5 +: 5] = data_tab[k];
        return r;
    endfunction

    task automatic set_data(input int d0, input int d1, input int d2, input int d3, input int d4);
        data_tab[0] = 5'(d0);
        data_tab[1] = 5'(d1);
        data_tab[2] = 5'(d2);
        data_tab[3] = 5'(d3);
        data_tab[4] = 5'(d4);
    endtask

    // Runs one sweep from a start pulse; lat = negedges from start to done (-1 if none).
    task automatic sweep(input int restart_at, output int lat, output int req2);
        logic [4:0] old2;
        int cyc;
        old2 = last_counts[14:10];
        @(negedge CLK);
        start = 1'b1;
        IDLE  = 1'b1;
        lat   = -1;
        req2  = 0;
        cyc   = 0;
        while (lat < 0 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            start = (cyc == restart_at);
            if (req && idx == 3'd2) begin
                req2++;
                check("no_capture_before_valid", 32'(counts[14:10]), 32'(old2));
            end
            if (done) lat = cyc;
        end
        start = 1'b0;
    endtask

    task automatic wait_req_idx(input logic [2:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req && idx == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        int          lat;
        int          req2;
        int          cnt;
        bit          ok;
        bit          any_req, any_err, any_busy;
        logic [24:0] exp;

        reset = 1'b0;
        start = 1'b0;
        IDLE  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            data_tab[k]  = '0;
            delay_tab[k] = 0;
        end
        last_counts = '0;

        #12;
        check("reset_req", 32'(req), 0);
        check("reset_idx", 32'(idx), 0);
        check("reset_counts", 32'(counts), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        @(negedge CLK);
        reset = 1'b1;

        // Baseline sweep, single-cycle responder.
        set_data(3, 7, 1, 0, 31);
        exp = model(last_counts, 5);
        exp_q.push_back(exp);
        sweep(-1, lat, req2);
        check("t1_latency", 32'(lat), 11);
        check("t1_counts_literal", 32'(counts), 32'({5'd31, 5'd0, 5'd1, 5'd7, 5'd3}));
        check("t1_counts_sb", 32'(counts), 32'(exp_q.pop_front()));
        check("t1_busy_at_done", 32'(busy), 0);
        check("t1_req_at_done", 32'(req), 0);
        check("t1_idx_at_done", 32'(idx), 4);
        last_counts = exp;
        @(negedge CLK);
        check("t1_done_one_cycle", 32'(done), 0);
        $display("t1 baseline sweep lat=%0d", lat);

        // Valid held off for idx 2.
        set_data(10, 20, 30, 5, 17);
        delay_tab[2] = 3;
        exp = model(last_counts, 5);
        exp_q.push_back(exp);
        sweep(-1, lat, req2);
        check("t2_latency", 32'(lat), 14);
        check("t2_req_hold_idx2", 32'(req2), 4);
        check("t2_counts_sb", 32'(counts), 32'(exp_q.pop_front()));
        last_counts = exp;
        delay_tab[2] = 0;
        $display("t2 delayed valid lat=%0d req2=%0d", lat, req2);

        // IDLE drops while idx 3 is outstanding.
        set_data(1, 2, 3, 4, 6);
        delay_tab[3] = 20;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_req_idx(3'd3, ok);
        check("t3_reached_idx3", 32'(ok), 1);
        exp = model(last_counts, 3);
        exp_q.push_back(exp);
        IDLE = 1'b0;
        @(negedge CLK);
        check("t3_err", 32'(err), 1);
        check("t3_req", 32'(req), 0);
        check("t3_busy", 32'(busy), 0);
        check("t3_no_done", 32'(done), 0);
        check("t3_counts_sb", 32'(counts), 32'(exp_q.pop_front()));
        last_counts = exp;
        IDLE = 1'b1;
        @(negedge CLK);
        check("t3_err_one_cycle", 32'(err), 0);
        delay_tab[3] = 0;
        $display("t3 abort at idx3 err observed");

        // Async reset mid-sweep, then a clean full sweep.
        set_data(9, 8, 7, 6, 5);
        delay_tab[1] = 6;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_req_idx(3'd1, ok);
        check("t4_reached_idx1", 32'(ok), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t4_async_counts", 32'(counts), 0);
        check("t4_async_req", 32'(req), 0);
        check("t4_async_busy", 32'(busy), 0);
        last_counts = '0;
        @(negedge CLK);
        reset = 1'b1;
        delay_tab[1] = 0;
        set_data(11, 12, 13, 14, 15);
        exp = model(last_counts, 5);
        exp_q.push_back(exp);
        sweep(-1, lat, req2);
        check("t4_latency", 32'(lat), 11);
        check("t4_counts_sb", 32'(counts), 32'(exp_q.pop_front()));
        last_counts = exp;
        $display("t4 async reset then sweep lat=%0d", lat);

        // start while not IDLE is ignored silently.
        @(negedge CLK);
        IDLE  = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start    = 1'b0;
        any_req  = 1'b0;
        any_err  = 1'b0;
        any_busy = 1'b0;
        repeat (5) begin
            any_req  = any_req | req;
            any_err  = any_err | err;
            any_busy = any_busy | busy;
            @(negedge CLK);
        end
        check("t5_no_req", 32'(any_req), 0);
        check("t5_no_err", 32'(any_err), 0);
        check("t5_no_busy", 32'(any_busy), 0);
        IDLE = 1'b1;
        $display("t5 start with IDLE low ignored");

        // Second start pulse mid-sweep must not perturb it.
        set_data(21, 22, 23, 24, 25);
        exp = model(last_counts, 5);
        exp_q.push_back(exp);
        sweep(5, lat, req2);
        check("t5_busy_restart_latency", 32'(lat), 11);
        check("t5_busy_restart_counts", 32'(counts), 32'(exp_q.pop_front()));
        last_counts = exp;
        $display("t5 start while busy lat=%0d", lat);

        // Responder never answers idx 0.
        delay_tab[0] = 1000000;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cnt = 0;
`ifdef CONTADOR_READER_TIMEOUT_EN
        for (int i = 0; i < 200; i++) begin
            if (err) break;
            if (req) cnt++;
            @(negedge CLK);
        end
        check("t6_timeout_wait", 32'(cnt), 15);
        check("t6_timeout_err", 32'(err), 1);
        check("t6_timeout_req", 32'(req), 0);
`else
        for (int i = 0; i < 120; i++) begin
            if (req) cnt++;
            @(negedge CLK);
        end
        check("t6_req_held", 32'(cnt), 120);
        IDLE = 1'b0;
        @(negedge CLK);
        check("t6_abort_err", 32'(err), 1);
        check("t6_abort_req", 32'(req), 0);
        IDLE = 1'b1;
`endif
        check("t6_counts_kept", 32'(counts), 32'(last_counts));
        delay_tab[0] = 0;
        $display("t6 stalled responder req_cycles=%0d", cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
